// File: rtl/memory_control_rr.sv
// memory_control_rr
// N-core snooping coherence controller and single-port RAM arbiter.
// Data (coherence) and instruction traffic are granted round-robin, with a
// fairness toggle so a pending ifetch is served after every data transfer.
// A data read snoops every other cache, waits for all acks, then either
// reads RAM or takes the block cache-to-cache from the lowest dirty
// responder while writing it back to RAM in the same beat.
//
// Ports (flattened per-core buses; core i occupies bits [i*32 +: 32]):
//   CLK, RST              clock, synchronous active-high reset
//   iREN/iaddr            instruction read request / word address per core
//   iwait/iload           instruction wait (low one cycle = valid) / data
//   dREN/dWEN             data read / write request per cache
//   daddr/dstore          data address / store data, driven per beat
//   dwait/dload           data wait / read data per cache
//   cctrans/ccwrite       coherence request or snoop ack / BusRdX or dirty
//   ccwait/ccinv          snoop stall / invalidate per cache
//   ccsnoopaddr           snoop address (granted data address, all cores)
//   ramload/ramstate      RAM read data / status (0 FREE,1 BUSY,2 ACCESS,3 ERROR)
//   ramREN/ramWEN         RAM read / write enable
//   ramaddr/ramstore      RAM address / write data
module memory_control_rr #(
  parameter int CPUS  = 4,
  parameter int WORDS = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*32-1:0]   iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS*32-1:0]   iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*32-1:0]   dload,
  input  logic [CPUS-1:0]      cctrans,
  input  logic [CPUS-1:0]      ccwrite,
  output logic [CPUS-1:0]      ccwait,
  output logic [CPUS-1:0]      ccinv,
  output logic [CPUS*32-1:0]   ccsnoopaddr,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore
);

  localparam int GW = $clog2(CPUS);
  localparam int BW = $clog2(WORDS) + 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SNOOP, S_RAMRD, S_C2C, S_WB, S_IFETCH
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     dgrant_q, dgrant_d, igrant_q, igrant_d, sup_q, sup_d;
  logic [GW-1:0]     last_data_q, last_data_d, last_inst_q, last_inst_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [CPUS-1:0]   ackmask_q, ackmask_d, dirty_q, dirty_d;
  logic              ifirst_q, ifirst_d;

  logic [CPUS-1:0]   others, ack_new, dirty_new;
  logic [31:0]       granted_addr;
  logic              access, last_beat, snoop_hold;
  int                dg, ig, sp;

  // First requester strictly after 'last', wrapping.
  function automatic logic [GW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                            input logic [GW-1:0] last);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= CPUS; k++) begin
      idx = (int'(last) + k) % CPUS;
      if (!found && req[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [GW-1:0] lowest_set(input logic [CPUS-1:0] v);
    logic [GW-1:0] pick;
    pick = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if (v[k]) pick = GW'(k);
    end
    return pick;
  endfunction

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values computed by the combinational block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      dgrant_q    <= '0;
      igrant_q    <= '0;
      sup_q       <= '0;
      last_data_q <= GW'(CPUS - 1);  // core 0 wins the first grant
      last_inst_q <= GW'(CPUS - 1);
      beat_q      <= '0;
      ackmask_q   <= '0;
      dirty_q     <= '0;
      ifirst_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dgrant_q    <= dgrant_d;
      igrant_q    <= igrant_d;
      sup_q       <= sup_d;
      last_data_q <= last_data_d;
      last_inst_q <= last_inst_d;
      beat_q      <= beat_d;
      ackmask_q   <= ackmask_d;
      dirty_q     <= dirty_d;
      ifirst_q    <= ifirst_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    dgrant_d    = dgrant_q;
    igrant_d    = igrant_q;
    sup_d       = sup_q;
    last_data_d = last_data_q;
    last_inst_d = last_inst_q;
    beat_d      = beat_q;
    ackmask_d   = ackmask_q;
    dirty_d     = dirty_q;
    ifirst_d    = ifirst_q;

    iwait    = '1;
    dwait    = '1;
    ccwait   = '0;
    ccinv    = '0;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    dg           = int'(dgrant_q);
    ig           = int'(igrant_q);
    sp           = int'(sup_q);
    others       = ~({{(CPUS-1){1'b0}}, 1'b1} << dgrant_q);
    granted_addr = daddr[dg*32 +: 32];
    ccsnoopaddr  = {CPUS{granted_addr}};
    access       = (ramstate == RAM_ACCESS);
    last_beat    = (beat_q == BW'(WORDS - 1));
    ack_new      = ackmask_q | (cctrans & others);
    dirty_new    = dirty_q | (cctrans & ccwrite & others);
    // Responders stay stalled through the data beats; released on the last one.
    snoop_hold   = (state_q == S_SNOOP) ||
                   ((state_q == S_RAMRD || state_q == S_C2C) && !(access && last_beat));

    if (snoop_hold) begin
      ccwait = others;
      ccinv  = others & {CPUS{ccwrite[dg]}};
    end

    case (state_q)
      S_IDLE: begin
        if ((|cctrans) && (!ifirst_q || !(|iREN))) begin
          state_d  = S_ARB;
          dgrant_d = rr_pick(cctrans, last_data_q);
        end else if (|iREN) begin
          state_d  = S_IFETCH;
          igrant_d = rr_pick(iREN, last_inst_q);
        end
      end
      S_ARB: begin
        if (dREN[dg]) begin
          state_d   = S_SNOOP;
          ackmask_d = '0;
          dirty_d   = '0;
        end else if (dWEN[dg]) begin
          state_d = S_WB;
        end
      end
      S_SNOOP: begin
        ackmask_d = ack_new;
        dirty_d   = dirty_new;
        if ((ack_new & others) == others) begin
          if (|dirty_new) begin
            state_d = S_C2C;
            sup_d   = lowest_set(dirty_new);
          end else begin
            state_d = S_RAMRD;
          end
        end
      end
      S_RAMRD: begin
        ramREN              = 1'b1;
        ramaddr             = granted_addr;
        dload[dg*32 +: 32]  = ramload;
      end
      S_C2C: begin
        ramWEN              = 1'b1;
        ramaddr             = granted_addr;
        ramstore            = dstore[sp*32 +: 32];
        dload[dg*32 +: 32]  = dstore[sp*32 +: 32];
        ccinv[sp]           = ccwrite[dg];
      end
      S_WB: begin
        ramWEN   = 1'b1;
        ramaddr  = granted_addr;
        ramstore = dstore[dg*32 +: 32];
      end
      S_IFETCH: begin
        ramREN             = 1'b1;
        ramaddr            = iaddr[ig*32 +: 32];
        iload[ig*32 +: 32] = ramload;
        if (access) begin
          iwait[ig]   = 1'b0;
          last_inst_d = igrant_q;
          ifirst_d    = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Data beats: BUSY/ERROR simply hold; each ACCESS moves one word.
    if ((state_q == S_RAMRD || state_q == S_C2C || state_q == S_WB) && access) begin
      dwait[dg] = 1'b0;
      if (state_q == S_C2C) dwait[sp] = 1'b0;
      if (last_beat) begin
        state_d     = S_IDLE;
        beat_d      = '0;
        ackmask_d   = '0;
        last_data_d = dgrant_q;
        ifirst_d    = 1'b1;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end
  end

endmodule
